// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch / load-store) for one single-port memory.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: alternate winners on ties instead of data-first.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  // Handshake: a requester holds req and its fields until its gnt pulse; the
  // memory side takes mem_req_o on a cycle with mem_gnt_i=1 and later returns
  // exactly one mem_rvalid_i pulse for that request.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   owner;
  logic   any_req;
  logic   pick_d;
  logic   take;

  assign any_req = if_req_i | d_req_i;
  assign take    = (state == IDLE) & any_req & ~reset_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_d = 1 when the most recent grant went to the data side.
  logic last_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_d <= 1'b1;
    end else if (take) begin
      last_d <= pick_d;
    end
  end

  assign pick_d = d_req_i & ~(if_req_i & last_d);
`else
  assign pick_d = d_req_i;
`endif

  always_comb begin
    state_next  = state;
    if_gnt_o    = 1'b0;
    d_gnt_o     = 1'b0;
    if_rvalid_o = 1'b0;
    d_rvalid_o  = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          if_gnt_o   = ~pick_d;
          d_gnt_o    = pick_d;
          state_next = REQ;
        end
      end
      REQ: begin
        if (mem_gnt_i) state_next = RESP;
      end
      RESP: begin
        if_rvalid_o = mem_rvalid_i & ~owner;
        d_rvalid_o  = mem_rvalid_i & owner;
        if (mem_rvalid_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign if_rdata_o = mem_rdata_i;
  assign d_rdata_o  = mem_rdata_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      owner       <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      state <= state_next;
      if (take) begin
        mem_req_o <= 1'b1;
        owner     <= pick_d;
        if (pick_d) begin
          mem_we_o    <= d_we_i;
          mem_be_o    <= d_be_i;
          mem_addr_o  <= d_addr_i;
          mem_wdata_o <= d_wdata_i;
        end else begin
          // Fetches are full-word reads; write data is left as it was.
          mem_we_o   <= 1'b0;
          mem_be_o   <= '1;
          mem_addr_o <= if_addr_i;
        end
      end else if (state == REQ && mem_gnt_i) begin
        mem_req_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model checked every cycle plus directed literal checks.
// Build with MEM_ARB_ROUND_ROBIN_EN defined to check the alternating tie-break.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic          if_gnt_o;
  logic          if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          d_req_i = 1'b0;
  logic          d_we_i = 1'b0;
  logic [BW-1:0] d_be_i = '0;
  logic [AW-1:0] d_addr_i = '0;
  logic [DW-1:0] d_wdata_i = '0;
  logic          d_gnt_o;
  logic          d_rvalid_o;
  logic [DW-1:0] d_rdata_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [BW-1:0] mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int d_rv_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // A transaction is "open" from its grant until its response; it is
  // "accepted" once the memory has taken the request.
  bit            m_open = 1'b0;
  bit            m_accepted = 1'b0;
  bit            m_for_data = 1'b0;
  bit            m_last_data = 1'b1;
  logic          m_we = 1'b0;
  logic [BW-1:0] m_be = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  bit            e_take, e_data_wins, e_if_rv, e_d_rv;

  always @(negedge clk_i) begin
    if (reset_i) begin
      chk("rst_if_gnt", if_gnt_o, 0);
      chk("rst_d_gnt", d_gnt_o, 0);
      chk("rst_if_rvalid", if_rvalid_o, 0);
      chk("rst_d_rvalid", d_rvalid_o, 0);
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_mem_we", mem_we_o, 0);
      chk("rst_mem_be", mem_be_o, 0);
      chk("rst_mem_addr", mem_addr_o, 0);
      chk("rst_mem_wdata", mem_wdata_o, 0);
      m_open = 0; m_accepted = 0; m_for_data = 0; m_last_data = 1;
      m_we = 0; m_be = '0; m_addr = '0; m_wdata = '0;
    end else begin
      e_take = !m_open && (if_req_i || d_req_i);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      e_data_wins = d_req_i && !(if_req_i && m_last_data);
`else
      e_data_wins = d_req_i;
`endif
      e_if_rv = m_open && m_accepted && mem_rvalid_i && !m_for_data;
      e_d_rv  = m_open && m_accepted && mem_rvalid_i && m_for_data;
      chk("if_gnt", if_gnt_o, e_take && !e_data_wins);
      chk("d_gnt", d_gnt_o, e_take && e_data_wins);
      chk("if_rvalid", if_rvalid_o, e_if_rv);
      chk("d_rvalid", d_rvalid_o, e_d_rv);
      chk("mem_req", mem_req_o, m_open && !m_accepted);
      chk("mem_we", mem_we_o, m_we);
      chk("mem_be", mem_be_o, m_be);
      chk("mem_addr", mem_addr_o, m_addr);
      chk("mem_wdata", mem_wdata_o, m_wdata);
      if (e_if_rv) chk("if_rdata", if_rdata_o, mem_rdata_i);
      if (e_d_rv) chk("d_rdata", d_rdata_o, mem_rdata_i);
      if (e_take) begin
        m_open = 1; m_accepted = 0; m_for_data = e_data_wins; m_last_data = e_data_wins;
        if (e_data_wins) begin
          m_we = d_we_i; m_be = d_be_i; m_addr = d_addr_i; m_wdata = d_wdata_i;
        end else begin
          m_we = 0; m_be = '1; m_addr = if_addr_i;
        end
      end else if (m_open && !m_accepted && mem_gnt_i) begin
        m_accepted = 1;
      end else if (m_open && m_accepted && mem_rvalid_i) begin
        m_open = 0;
      end
    end
    d_rv_cnt += int'(d_rvalid_o);
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; directed checks look 1 unit later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic look();
    #1;
  endtask

  logic [1:0] got_q[$];
  logic [1:0] exp_q[$];
  int         cnt0;

  initial begin
    step(); step();
    reset_i = 1'b0;
    step();

    // Simultaneous requests held for four transactions (right after reset).
    if_req_i = 1; if_addr_i = 32'h40;
    d_req_i = 1; d_we_i = 0; d_be_i = 4'hF; d_addr_i = 32'h80;
    for (int i = 0; i < 4; i++) begin
      look();
      got_q.push_back({d_gnt_o, if_gnt_o});
      step(); mem_gnt_i = 1;
      step(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h1000 + i;
      step(); mem_rvalid_i = 0;
    end
    if_req_i = 0; d_req_i = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_q = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
    for (int i = 0; i < 4; i++) chk($sformatf("tie_order_%0d", i), got_q[i], exp_q[i]);
    step();

    // Single fetch.
    if_req_i = 1; if_addr_i = 32'h0000_0010;
    look(); chk("fetch_gnt", if_gnt_o, 1); chk("fetch_no_d_gnt", d_gnt_o, 0);
    step(); if_req_i = 0; mem_gnt_i = 1;
    look(); chk("fetch_mem_req", mem_req_o, 1); chk("fetch_mem_addr", mem_addr_o, 32'h10);
    chk("fetch_mem_be", mem_be_o, 4'hF); chk("fetch_mem_we", mem_we_o, 0);
    step(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0050_0093;
    look(); chk("fetch_rvalid", if_rvalid_o, 1); chk("fetch_rdata", if_rdata_o, 32'h0050_0093);
    chk("fetch_no_d_rvalid", d_rvalid_o, 0);
    step(); mem_rvalid_i = 0;
    step();

    // Store with the memory stalling its grant for three cycles.
    cnt0 = d_rv_cnt;
    d_req_i = 1; d_we_i = 1; d_be_i = 4'b0011; d_addr_i = 32'h100; d_wdata_i = 32'hDEAD_BEEF;
    look(); chk("store_gnt", d_gnt_o, 1);
    step(); d_req_i = 0;
    for (int k = 0; k < 4; k++) begin
      look();
      chk($sformatf("store_req_%0d", k), mem_req_o, 1);
      chk($sformatf("store_we_%0d", k), mem_we_o, 1);
      chk($sformatf("store_be_%0d", k), mem_be_o, 4'b0011);
      chk($sformatf("store_addr_%0d", k), mem_addr_o, 32'h100);
      chk($sformatf("store_wdata_%0d", k), mem_wdata_o, 32'hDEAD_BEEF);
      if (k == 3) mem_gnt_i = 1;
      step();
    end
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0;
    step(); mem_rvalid_i = 0;
    step(); step();
    chk("store_rvalid_pulses", d_rv_cnt - cnt0, 1);

    // Stray responses in IDLE and in REQ.
    mem_rvalid_i = 1;
    look(); chk("stray_idle_if_rv", if_rvalid_o, 0); chk("stray_idle_d_rv", d_rvalid_o, 0);
    step(); mem_rvalid_i = 0; if_req_i = 1; if_addr_i = 32'h20;
    look(); chk("stray_idle_kept", if_gnt_o, 1);
    step(); if_req_i = 0; mem_rvalid_i = 1;
    look(); chk("stray_req_if_rv", if_rvalid_o, 0); chk("stray_req_mem_req", mem_req_o, 1);
    step(); mem_rvalid_i = 0;
    look(); chk("stray_req_kept", mem_req_o, 1);
    mem_gnt_i = 1;
    step(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h1234_5678;
    look(); chk("stray_then_resp", if_rvalid_o, 1);
    step(); mem_rvalid_i = 0;
    step();

    // Reset in the middle of a data response.
    d_req_i = 1; d_we_i = 0; d_be_i = 4'hF; d_addr_i = 32'h200;
    look(); chk("rst_load_gnt", d_gnt_o, 1);
    step(); d_req_i = 0; mem_gnt_i = 1;
    step(); mem_gnt_i = 0; mem_rdata_i = '0; reset_i = 1;
    look();
    chk("async_mem_req", mem_req_o, 0); chk("async_mem_we", mem_we_o, 0);
    chk("async_mem_be", mem_be_o, 0); chk("async_mem_addr", mem_addr_o, 0);
    chk("async_mem_wdata", mem_wdata_o, 0); chk("async_gnts", {if_gnt_o, d_gnt_o}, 0);
    chk("async_rvalids", {if_rvalid_o, d_rvalid_o}, 0);
    chk("async_rdata", {if_rdata_o, d_rdata_o}, 0);
    step(); reset_i = 0;
    step(); mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE_F00D;
    look(); chk("late_resp_d_rv", d_rvalid_o, 0); chk("late_resp_if_rv", if_rvalid_o, 0);
    chk("late_resp_mem_req", mem_req_o, 0);
    step(); mem_rvalid_i = 0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
